// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Op select, FSM states and divider constants.
package muldiv_pkg;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   localparam int DIV_ITERS = 32;
   localparam logic [31:0] DIVZ_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_WAIT,
      S_DIV_RUN,
      S_DIV_FIX,
      S_DONE
   } state_t;

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// Request/result bundle between the control unit and the HI/LO unit.
// master = requester (control unit), slave = muldiv_hilo_unit.
interface muldiv_hilo_unit_if;

   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        div_by_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, hi_out, lo_out, div_by_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi_out, lo_out, div_by_zero
   );

endinterface

// File: rtl/booth.sv
// Combinational radix-2 Booth multiplier, 32x32 signed -> 64-bit.
// Settles over several cycles; the caller waits before sampling.
module booth (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_p
);

   logic [63:0] w_ae;
   logic [32:0] w_bx;

   assign w_ae = {{32{i_a[31]}}, i_a};
   assign w_bx = {i_b, 1'b0};

   always_comb begin
      o_p = '0;
      for (int i = 0; i < 32; i++) begin
         case (w_bx[i +: 2])
            2'b01:   o_p = o_p + (w_ae << i);
            2'b10:   o_p = o_p - (w_ae << i);
            default: o_p = o_p;
         endcase
      end
   end

endmodule

// File: rtl/muldiv_hilo_unit_nr_divider.sv
// Non-restoring signed divider, one quotient bit per step strobe.
// Present only when MULDIV_DIV_EN is defined.
`ifdef MULDIV_DIV_EN
module nr_divider (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        i_load,
   input  logic        i_step,
   input  logic        i_fix,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_q,
   output logic [31:0] o_r
);

   logic [32:0] r_rem;
   logic [31:0] r_q;
   logic [31:0] r_d;
   logic        r_sa;
   logic        r_sq;

   logic [31:0] w_ma;
   logic [31:0] w_mb;
   logic [32:0] w_sh;
   logic [32:0] w_rem_nxt;
   logic [32:0] w_rem_fix;

   assign w_ma = i_a[31] ? -i_a : i_a;
   assign w_mb = i_b[31] ? -i_b : i_b;

   // |b| <= 2^31, so 2*rem+bit always fits in 33 signed bits
   assign w_sh      = {r_rem[31:0], r_q[31]};
   assign w_rem_nxt = r_rem[32] ? w_sh + {1'b0, r_d}
                                : w_sh - {1'b0, r_d};
   assign w_rem_fix = r_rem[32] ? r_rem + {1'b0, r_d} : r_rem;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_rem <= '0;
         r_q   <= '0;
         r_d   <= '0;
         r_sa  <= 1'b0;
         r_sq  <= 1'b0;
      end else if (i_load) begin
         r_rem <= '0;
         r_q   <= w_ma;
         r_d   <= w_mb;
         r_sa  <= i_a[31];
         r_sq  <= i_a[31] ^ i_b[31];
      end else if (i_step) begin
         r_rem <= w_rem_nxt;
         r_q   <= {r_q[30:0], ~w_rem_nxt[32]};
      end else if (i_fix) begin
         r_rem <= r_sa ? {1'b0, -w_rem_fix[31:0]}
                       : {1'b0, w_rem_fix[31:0]};
         r_q   <= r_sq ? -r_q : r_q;
      end
   end

   assign o_q = r_q;
   assign o_r = r_rem[31:0];

endmodule
`endif

// File: rtl/muldiv_hilo_unit.sv
// HI/LO multiply/divide front-end around booth and nr_divider.
// Divider compiled in only when MULDIV_DIV_EN is defined.
module muldiv_hilo_unit
   import muldiv_pkg::*;
#(
   parameter int MUL_LAT = 2
) (
   input logic               clk,
   input logic               clr_n,
   muldiv_hilo_unit_if.slave bus
);

   state_t      r_state;
   state_t      w_next;
   logic [5:0]  r_cnt;
   logic [5:0]  w_cnt_nxt;
   logic        r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_busy;
   logic        r_done;
   logic        w_accept;
   logic        w_cap_mul;
   logic [63:0] w_prod;

   booth u_booth (
      .i_a (r_a),
      .i_b (r_b),
      .o_p (w_prod)
   );

`ifdef MULDIV_DIV_EN
   logic        r_dbz;
   logic        w_load;
   logic        w_step;
   logic        w_fix;
   logic        w_cap_div;
   logic        w_cap_dbz;
   logic [31:0] w_q;
   logic [31:0] w_r;

   assign w_load = w_accept && (bus.op == OP_DIV);

   nr_divider u_div (
      .clk    (clk),
      .clr_n  (clr_n),
      .i_load (w_load),
      .i_step (w_step),
      .i_fix  (w_fix),
      .i_a    (bus.a),
      .i_b    (bus.b),
      .o_q    (w_q),
      .o_r    (w_r)
   );

   assign bus.div_by_zero = r_dbz;
`else
   assign bus.div_by_zero = 1'b0;
`endif

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_accept  = 1'b0;
      w_cap_mul = 1'b0;
`ifdef MULDIV_DIV_EN
      w_step    = 1'b0;
      w_fix     = 1'b0;
      w_cap_div = 1'b0;
      w_cap_dbz = 1'b0;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept = 1'b1;
               if (bus.op == OP_MUL) begin
                  w_next    = S_MUL_WAIT;
                  w_cnt_nxt = 6'(MUL_LAT);
               end else begin
`ifdef MULDIV_DIV_EN
                  w_next    = S_DIV_RUN;
                  w_cnt_nxt = 6'(DIV_ITERS);
`else
                  // no divider: a single pass-through cycle, no capture
                  w_next    = S_MUL_WAIT;
                  w_cnt_nxt = '0;
`endif
               end
            end
         end
         S_MUL_WAIT: begin
            if (r_cnt == '0) begin
               w_next    = S_DONE;
               w_cap_mul = (r_op == OP_MUL);
            end else begin
               w_cnt_nxt = r_cnt - 6'd1;
            end
         end
`ifdef MULDIV_DIV_EN
         S_DIV_RUN: begin
            if (r_b == '0) begin
               w_next    = S_DONE;
               w_cap_dbz = 1'b1;
            end else begin
               w_step = 1'b1;
               if (r_cnt == 6'd1) w_next = S_DIV_FIX;
               else w_cnt_nxt = r_cnt - 6'd1;
            end
         end
         // first cycle applies the fix-up, second captures it
         S_DIV_FIX: begin
            if (r_cnt != '0) begin
               w_fix     = 1'b1;
               w_cnt_nxt = '0;
            end else begin
               w_cap_div = 1'b1;
               w_next    = S_DONE;
            end
         end
`endif
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= OP_MUL;
         r_a     <= '0;
         r_b     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef MULDIV_DIV_EN
         r_dbz   <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_next != S_IDLE);
         r_done  <= (w_next == S_DONE);
         if (w_accept) begin
            r_op <= bus.op;
            r_a  <= bus.a;
            r_b  <= bus.b;
`ifdef MULDIV_DIV_EN
            r_dbz <= 1'b0;
`endif
         end
         if (w_cap_mul) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
         end
`ifdef MULDIV_DIV_EN
         if (w_cap_div) begin
            r_hi <= w_r;
            r_lo <= w_q;
         end
         if (w_cap_dbz) begin
            r_hi  <= r_a;
            r_lo  <= DIVZ_QUOT;
            r_dbz <= 1'b1;
         end
`endif
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.hi_out = r_hi;
   assign bus.lo_out = r_lo;

endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Sequential multiply/divide front-end that issues operands to the existing combinational `booth` multiplier and consumes its 64-bit product into the HI/LO register pair. It also performs signed 32-bit division with a non-restoring, one-bit-per-cycle divider. It sits between the register-file/ALU operand buses and the HI/LO registers, and exposes a start/busy/done handshake to the control unit.

## Interface
- `MUL_LAT`, default 2: cycles allowed for the combinational `booth` product to settle before capture. Legal range is 1..15.
- `clk`, input, 1: rising-edge clock.
- `clr_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: request. Sampled only in IDLE.
- `op`, input, 1: operation select. 0 = MUL, 1 = DIV.
- `a`, input, 32: signed multiplicand or dividend.
- `b`, input, 32: signed multiplier or divisor.
- `busy`, output, 1: high whenever state is not IDLE.
- `done`, output, 1: one-cycle pulse. HI/LO are valid while it is high.
- `hi_out`, output, 32: HI register. Holds the product's upper word, or the remainder.
- `lo_out`, output, 32: LO register. Holds the product's lower word, or the quotient.
- `div_by_zero`, output, 1: set by a DIV with `b`=0. Cleared when the next request is accepted.

## Operation
- States are IDLE, MUL_WAIT, DIV_RUN, DIV_FIX and DONE. DONE always returns to IDLE.
- Accept: `start` is accepted only when state is IDLE and `clr_n`=1. On accept, `a`, `b` and `op` are latched into operand registers. `start` is ignored in every other state, so there is no queueing.
- MUL path:
  - The latched operands drive the `booth` instance directly.
  - The settle counter loads `MUL_LAT` and decrements once per cycle in MUL_WAIT.
  - When the count reaches 0: `hi_out` takes product[63:32], `lo_out` takes product[31:0], and the state moves to DONE.
  - The product is exact two's-complement with no overflow possible.
- DIV path:
  - Divide magnitudes |a| and |b| as 32-bit unsigned values, so |0x80000000| = 0x80000000.
  - DIV_RUN performs 32 non-restoring iterations, one quotient bit per cycle. The partial remainder is 33 bits signed.
  - DIV_FIX applies the final restore (add |b| if the remainder is negative), then applies signs: the quotient is negated if sign(a) differs from sign(b), and the remainder is negated if a<0.
  - Rounding is truncation toward zero; the remainder takes the dividend's sign.
  - Results go to LO = quotient and HI = remainder, with wrap-around. 0x80000000 / -1 gives LO=0x80000000, HI=0.
- Divide by zero: if `b`=0 at accept, DIV_RUN is skipped. The next state is DONE with HI=`a`, LO=0xFFFFFFFF and `div_by_zero`=1.
- Result hold: `hi_out` and `lo_out` hold their values until the next completion. They never change outside the DONE entry.
- Reset: while `clr_n`=0 at an edge, state returns to IDLE and every output, counter and operand register goes to 0. This includes mid-operation; the in-flight result is discarded. Reset wins over a simultaneous `start`.

## Timing
- Cycle numbering: accept at edge k.
- MUL: `busy` rises at k. `done`, `hi_out` and `lo_out` update at edge k+`MUL_LAT`+1. `busy` falls at k+`MUL_LAT`+2.
- DIV: iterations run on edges k+1..k+32, DIV_FIX is at k+33, and `done` is at k+34. `busy` falls at k+35.
- DIV with `b`=0: `done` at k+1.
- Back-to-back: the earliest next accept is the edge after `done` is seen, i.e. the cycle when IDLE is re-entered plus `start`.
- `done` and `busy` are registered outputs with no combinational path from the inputs.

## Configuration
- `MULDIV_DIV_EN` defined: the full divider, DIV_RUN/DIV_FIX states and `div_by_zero` logic are compiled in.
- `MULDIV_DIV_EN` undefined:
  - DIV requests are accepted and go directly to DONE at k+1.
  - HI/LO are left unchanged, and `div_by_zero` is tied to 0.
  - The divider logic is absent and the MUL path is unaffected.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings `OP_MUL`=1'b0 and `OP_DIV`=1'b1;
  - the state encoding;
  - `DIV_ITERS`=32;
  - `DIVZ_QUOT`=32'hFFFFFFFF.
- The existing `booth` multiplier is instantiated unchanged.
- The divider datapath (33-bit partial remainder, quotient shift register, restore and sign fix-up) lives in one sub-module, `nr_divider`, with `load`/`step`/`fix` strobes from this block's FSM.

## Test plan
- MUL, `MUL_LAT`=2, a=0xFFFFFFCB (-53), b=0xFFFFFFC2 (-62) -> at k+3: `done`=1, HI=0x00000000, LO=0x00000CD6.
- DIV, a=100, b=-7 -> at k+34: LO=0xFFFFFFF2, HI=0x00000002. Also a=-100, b=7 -> LO=0xFFFFFFF2, HI=0xFFFFFFFE.
- DIV, a=5, b=0 -> at k+1: HI=0x00000005, LO=0xFFFFFFFF, `div_by_zero`=1. The next accepted MUL clears the flag.
- DIV, a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, `div_by_zero`=0.
- `start` held high through a DIV -> exactly one result. A second MUL is accepted only after DONE, and HI/LO are unchanged until its own `done`.
- `clr_n`=0 at k+10 of a DIV -> next edge: `busy`=0, HI=LO=0, no `done`. With `MULDIV_DIV_EN` undefined, DIV -> `done` at k+1 with HI/LO unchanged.
